// File: rtl/seg7_pkg.sv
// Shared types, segment pattern constants and digit arithmetic for the 7-segment counter/monitor pair.
// Optional hexadecimal digits A-F are enabled by defining SEG7_HEX_EN.
package seg7_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] digit_t;

    // Active-low patterns, bit 6 = segment a ... bit 0 = segment g.
    localparam seg7_t SEG_0     = 7'b000_0001;
    localparam seg7_t SEG_1     = 7'b100_1111;
    localparam seg7_t SEG_2     = 7'b001_0010;
    localparam seg7_t SEG_3     = 7'b000_0110;
    localparam seg7_t SEG_4     = 7'b100_1100;
    localparam seg7_t SEG_5     = 7'b010_0100;
    localparam seg7_t SEG_6     = 7'b010_0000;
    localparam seg7_t SEG_7     = 7'b000_1111;
    localparam seg7_t SEG_8     = 7'b000_0000;
    localparam seg7_t SEG_9     = 7'b000_0100;
    localparam seg7_t SEG_A     = 7'b000_1000;
    localparam seg7_t SEG_B     = 7'b110_0000;
    localparam seg7_t SEG_C     = 7'b011_0001;
    localparam seg7_t SEG_D     = 7'b100_0010;
    localparam seg7_t SEG_E     = 7'b011_0000;
    localparam seg7_t SEG_F     = 7'b011_1000;
    localparam seg7_t SEG_BLANK = 7'b111_1111;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_JUMP = 2'b11
    } dir_e;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_TRACK = 2'b01;
    localparam logic [1:0] ST_ERR   = 2'b10;

`ifdef SEG7_HEX_EN
    localparam digit_t DIGIT_MAX = 4'd15;
`else
    localparam digit_t DIGIT_MAX = 4'd9;
`endif

    function automatic digit_t digit_up(input digit_t d);
        if (d == DIGIT_MAX) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    function automatic digit_t digit_dn(input digit_t d);
        if (d == 4'd0) begin
            return DIGIT_MAX;
        end else begin
            return d - 4'd1;
        end
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder; A-F are legal only when SEG7_HEX_EN is defined.
module seg7_decode
    import seg7_pkg::*;
(
    input  seg7_t  seg_i,
    output logic   legal_o,
    output digit_t digit_o
);

    // Map each known pattern to its digit; everything else (including blank) is illegal.
    always_comb begin
        legal_o = 1'b1;
        digit_o = 4'd0;
        case (seg_i)
            SEG_0: digit_o = 4'd0;
            SEG_1: digit_o = 4'd1;
            SEG_2: digit_o = 4'd2;
            SEG_3: digit_o = 4'd3;
            SEG_4: digit_o = 4'd4;
            SEG_5: digit_o = 4'd5;
            SEG_6: digit_o = 4'd6;
            SEG_7: digit_o = 4'd7;
            SEG_8: digit_o = 4'd8;
            SEG_9: digit_o = 4'd9;
`ifdef SEG7_HEX_EN
            SEG_A: digit_o = 4'd10;
            SEG_B: digit_o = 4'd11;
            SEG_C: digit_o = 4'd12;
            SEG_D: digit_o = 4'd13;
            SEG_E: digit_o = 4'd14;
            SEG_F: digit_o = 4'd15;
`endif
            default: begin
                legal_o = 1'b0;
                digit_o = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_decade_monitor.sv
// Watches a 7-segment bus, debounces it, recovers the digit and classifies each accepted change.
// Define SEG7_HEX_EN to accept hexadecimal digits A-F with modulo-16 up/down arithmetic.
module seg7_decade_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 2,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [6:0]        seg,
    input  logic              seg_stb,
    output logic [3:0]        digit,
    output logic              digit_valid,
    output logic              seg_err,
    output logic [1:0]        dir,
    output logic              acc,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic [WRAP_W-1:0] tens
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);

    seg7_t             cand_q, cand_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        state_q, state_d;
    digit_t            digit_q, digit_d;
    logic              digit_valid_q, digit_valid_d;
    logic              seg_err_q, seg_err_d;
    logic [1:0]        dir_q, dir_d;
    logic              acc_q, acc_d;
    logic              wrap_up_q, wrap_up_d;
    logic              wrap_dn_q, wrap_dn_d;
    logic [WRAP_W-1:0] tens_q, tens_d;
    logic              accept_s;
    logic              dec_legal_s;
    digit_t            dec_digit_s;

    // The live sample is decoded; on an accept it is identical to the new candidate.
    seg7_decode u_decode (
        .seg_i   (seg),
        .legal_o (dec_legal_s),
        .digit_o (dec_digit_s)
    );

    // Debounce, accept detection, FSM, direction classifier and tens counter.
    always_comb begin
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        seg_err_d     = seg_err_q;
        dir_d         = dir_q;
        acc_d         = 1'b0;
        wrap_up_d     = 1'b0;
        wrap_dn_d     = 1'b0;
        tens_d        = tens_q;
        accept_s      = 1'b0;

        // Saturating run counter: an accept fires only on the edge the run reaches STABLE_MAX.
        if (seg_stb) begin
            if (seg == cand_q) begin
                if (cnt_q < STABLE_MAX) begin
                    cnt_d    = cnt_q + 4'd1;
                    accept_s = ((cnt_q + 4'd1) == STABLE_MAX);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cand_d   = seg;
                cnt_d    = 4'd1;
                accept_s = (STABLE_MAX == 4'd1);
            end
        end else begin
            accept_s = 1'b0;
        end

        if (accept_s) begin
            acc_d = 1'b1;
            if (dec_legal_s) begin
                state_d       = ST_TRACK;
                digit_d       = dec_digit_s;
                digit_valid_d = 1'b1;
                seg_err_d     = 1'b0;
                case (state_q)
                    ST_TRACK: begin
                        if (dec_digit_s == digit_q) begin
                            dir_d = DIR_HOLD;
                        end else if (dec_digit_s == digit_up(digit_q)) begin
                            dir_d = DIR_UP;
                            if (digit_q == DIGIT_MAX) begin
                                wrap_up_d = 1'b1;
                                tens_d    = tens_q + WRAP_W'(1'b1);
                            end else begin
                                wrap_up_d = 1'b0;
                            end
                        end else if (dec_digit_s == digit_dn(digit_q)) begin
                            dir_d = DIR_DOWN;
                            if (digit_q == 4'd0) begin
                                wrap_dn_d = 1'b1;
                                tens_d    = tens_q - WRAP_W'(1'b1);
                            end else begin
                                wrap_dn_d = 1'b0;
                            end
                        end else begin
                            dir_d = DIR_JUMP;
                        end
                    end
                    ST_ERR:  dir_d = DIR_JUMP;
                    default: dir_d = DIR_HOLD;
                endcase
            end else begin
                state_d       = ST_ERR;
                digit_valid_d = 1'b0;
                seg_err_d     = 1'b1;
                dir_d         = DIR_JUMP;
            end
        end else begin
            acc_d = 1'b0;
        end
    end

    // State registers with synchronous clear; clear also discards any candidate in progress.
    always_ff @(posedge clk) begin
        if (clr) begin
            cand_q        <= SEG_BLANK;
            cnt_q         <= 4'd0;
            state_q       <= ST_EMPTY;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            dir_q         <= DIR_HOLD;
            acc_q         <= 1'b0;
            wrap_up_q     <= 1'b0;
            wrap_dn_q     <= 1'b0;
            tens_q        <= '0;
        end else begin
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            seg_err_q     <= seg_err_d;
            dir_q         <= dir_d;
            acc_q         <= acc_d;
            wrap_up_q     <= wrap_up_d;
            wrap_dn_q     <= wrap_dn_d;
            tens_q        <= tens_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign seg_err     = seg_err_q;
    assign dir         = dir_q;
    assign acc         = acc_q;
    assign wrap_up     = wrap_up_q;
    assign wrap_dn     = wrap_dn_q;
    assign tens        = tens_q;

endmodule

// File: tb/tb_seg7_decade_monitor.sv
// Self-checking bench for seg7_decade_monitor: directed scenarios plus randomized traffic against a reference model.
module tb_seg7_decade_monitor;

    localparam int STB = 2;
    localparam int WW  = 8;
`ifdef SEG7_HEX_EN
    localparam int NDIG = 16;
`else
    localparam int NDIG = 10;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [6:0]    seg = 7'h7F;
    logic          seg_stb = 1'b0;
    logic [3:0]    digit;
    logic          digit_valid, seg_err, acc, wrap_up, wrap_dn;
    logic [1:0]    dir;
    logic [WW-1:0] tens;

    int checks = 0;
    int failures = 0;

    // Digit patterns, active-low a..g, as listed for the display.
    logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reference model state
    logic [6:0] m_cand;
    int         m_run, m_digit, m_tens, m_mode;  // mode: 0 empty, 1 tracking, 2 error
    logic       m_valid, m_err, m_acc, m_wu, m_wd;
    logic [1:0] m_dir;

    seg7_decade_monitor #(.STABLE_CNT(STB), .WRAP_W(WW)) dut (
        .clk(clk), .clr(clr), .seg(seg), .seg_stb(seg_stb),
        .digit(digit), .digit_valid(digit_valid), .seg_err(seg_err), .dir(dir),
        .acc(acc), .wrap_up(wrap_up), .wrap_dn(wrap_dn), .tens(tens)
    );

    always #5 clk = ~clk;

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < NDIG; i++) begin
            if (pat[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [6:0] s, input logic stb, input logic c);
        int d, diff;
        m_acc = 1'b0; m_wu = 1'b0; m_wd = 1'b0;
        if (c) begin
            m_cand = 7'h7F; m_run = 0; m_digit = 0; m_tens = 0; m_mode = 0;
            m_valid = 1'b0; m_err = 1'b0; m_dir = 2'b00;
        end else if (stb) begin
            if (s == m_cand) m_run++;
            else begin m_cand = s; m_run = 1; end
            if (m_run == STB) begin
                m_acc = 1'b1;
                d = lookup(s);
                if (d >= 0) begin
                    diff = (d - m_digit + NDIG) % NDIG;
                    if (m_mode == 0) m_dir = 2'b00;
                    else if (m_mode == 2) m_dir = 2'b11;
                    else if (diff == 0) m_dir = 2'b00;
                    else if (diff == 1) begin
                        m_dir = 2'b01;
                        if (d == 0) begin m_wu = 1'b1; m_tens = (m_tens + 1) % (1 << WW); end
                    end else if (diff == NDIG - 1) begin
                        m_dir = 2'b10;
                        if (d == NDIG - 1) begin m_wd = 1'b1; m_tens = (m_tens + (1 << WW) - 1) % (1 << WW); end
                    end else m_dir = 2'b11;
                    m_mode = 1; m_digit = d; m_valid = 1'b1; m_err = 1'b0;
                end else begin
                    m_mode = 2; m_valid = 1'b0; m_err = 1'b1; m_dir = 2'b11;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [6:0] s, input logic stb, input logic c);
        @(negedge clk);
        seg = s; seg_stb = stb; clr = c;
        @(posedge clk);
        model_update(s, stb, c);
        #1;
    endtask

    task automatic present(input logic [6:0] s);
        for (int i = 0; i < STB; i++) step(s, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        step(7'h7F, 1'b0, 1'b1);
        checks++;
        if ({digit, digit_valid, seg_err, dir, acc, wrap_up, wrap_dn, tens} !== {4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            failures++; $display("FAIL reset_state: got d=%0d v=%b e=%b dir=%b acc=%b tens=%0d", digit, digit_valid, seg_err, dir, acc, tens);
        end
        for (int i = 0; i < 10; i++) begin
            step(7'($urandom), 1'b0, 1'b0);
            checks++;
            if ({acc, digit, digit_valid, tens} !== {1'b0, 4'd0, 1'b0, 8'd0}) begin
                failures++; $display("FAIL idle_no_acc: got acc=%b d=%0d v=%b tens=%0d want 0", acc, digit, digit_valid, tens);
            end
        end
    endtask

    task automatic test_debounce;
        step(pat[0], 1'b1, 1'b0);
        step(pat[1], 1'b1, 1'b0);
        checks++;
        if (acc !== 1'b0 || digit_valid !== 1'b0) begin
            failures++; $display("FAIL debounce_early: got acc=%b v=%b want 0 0", acc, digit_valid);
        end
        step(pat[1], 1'b1, 1'b0);
        checks++;
        if ({acc, digit, digit_valid, seg_err, dir} !== {1'b1, 4'd1, 1'b1, 1'b0, 2'b00}) begin
            failures++; $display("FAIL debounce_accept: got acc=%b d=%0d v=%b e=%b dir=%b want 1 1 1 0 00", acc, digit, digit_valid, seg_err, dir);
        end
        step(pat[1], 1'b1, 1'b0);
        checks++;
        if (acc !== 1'b0) begin
            failures++; $display("FAIL debounce_no_reaccept: got acc=%b want 0", acc);
        end
    endtask

    task automatic test_up_wrap;
        logic [1:0] want_dir [4] = '{2'b11, 2'b01, 2'b01, 2'b01};
        int         seq [4] = '{7, 8, 9, 0};
        for (int i = 0; i < 4; i++) begin
            present(pat[seq[i]]);
            checks++;
            if ({acc, digit, dir, wrap_up, wrap_dn, tens} !== {1'b1, 4'(seq[i]), want_dir[i], (i == 3), 1'b0, (i == 3) ? 8'd1 : 8'd0}) begin
                failures++; $display("FAIL up_step%0d: got acc=%b d=%0d dir=%b wu=%b wd=%b tens=%0d", i, acc, digit, dir, wrap_up, wrap_dn, tens);
            end
        end
        step(pat[0], 1'b0, 1'b0);
        checks++;
        if ({acc, wrap_up, tens} !== {1'b0, 1'b0, 8'd1}) begin
            failures++; $display("FAIL up_pulse_width: got acc=%b wu=%b tens=%0d want 0 0 1", acc, wrap_up, tens);
        end
    endtask

    task automatic test_down_wrap;
        present(pat[9]);
        checks++;
        if ({digit, dir, wrap_dn, wrap_up, tens} !== {4'd9, 2'b10, 1'b1, 1'b0, 8'd0}) begin
            failures++; $display("FAIL down_wrap1: got d=%0d dir=%b wd=%b wu=%b tens=%0d", digit, dir, wrap_dn, wrap_up, tens);
        end
        present(pat[5]);
        present(pat[0]);
        checks++;
        if ({dir, wrap_up, tens} !== {2'b11, 1'b0, 8'd0}) begin
            failures++; $display("FAIL down_jump: got dir=%b wu=%b tens=%0d want 11 0 0", dir, wrap_up, tens);
        end
        present(pat[9]);
        checks++;
        if ({dir, wrap_dn, tens} !== {2'b10, 1'b1, 8'd255}) begin
            failures++; $display("FAIL down_wrap_underflow: got dir=%b wd=%b tens=%0d want 10 1 255", dir, wrap_dn, tens);
        end
    endtask

    task automatic test_error;
        present(7'h7F);
        checks++;
        if ({acc, seg_err, digit_valid, digit, dir, tens} !== {1'b1, 1'b1, 1'b0, 4'd9, 2'b11, 8'd255}) begin
            failures++; $display("FAIL err_enter: got acc=%b e=%b v=%b d=%0d dir=%b tens=%0d", acc, seg_err, digit_valid, digit, dir, tens);
        end
        present(pat[3]);
        checks++;
        if ({seg_err, digit_valid, digit, dir, wrap_up, wrap_dn} !== {1'b0, 1'b1, 4'd3, 2'b11, 1'b0, 1'b0}) begin
            failures++; $display("FAIL err_recover: got e=%b v=%b d=%0d dir=%b wu=%b wd=%b", seg_err, digit_valid, digit, dir, wrap_up, wrap_dn);
        end
    endtask

    task automatic test_clr_mid;
        step(pat[4], 1'b1, 1'b0);
        step(pat[4], 1'b1, 1'b1);
        checks++;
        if ({digit, digit_valid, seg_err, dir, acc, tens} !== {4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0}) begin
            failures++; $display("FAIL clr_mid_state: got d=%0d v=%b e=%b dir=%b acc=%b tens=%0d", digit, digit_valid, seg_err, dir, acc, tens);
        end
        step(pat[4], 1'b1, 1'b0);
        checks++;
        if (acc !== 1'b0) begin
            failures++; $display("FAIL clr_mid_dropped: got acc=%b want 0", acc);
        end
        step(pat[4], 1'b1, 1'b0);
        checks++;
        if ({acc, digit, dir} !== {1'b1, 4'd4, 2'b00}) begin
            failures++; $display("FAIL clr_mid_reaccept: got acc=%b d=%0d dir=%b want 1 4 00", acc, digit, dir);
        end
    endtask

    task automatic test_hex;
`ifdef SEG7_HEX_EN
        present(pat[9]);
        present(pat[10]);
        checks++;
        if ({digit, dir, digit_valid} !== {4'd10, 2'b01, 1'b1}) begin
            failures++; $display("FAIL hex_9_to_A: got d=%0d dir=%b v=%b want 10 01 1", digit, dir, digit_valid);
        end
        present(pat[15]);
        present(pat[0]);
        checks++;
        if ({digit, dir, wrap_up, tens} !== {4'd0, 2'b01, 1'b1, 8'd1}) begin
            failures++; $display("FAIL hex_F_to_0: got d=%0d dir=%b wu=%b tens=%0d want 0 01 1 1", digit, dir, wrap_up, tens);
        end
`else
        present(pat[10]);
        checks++;
        if ({seg_err, digit_valid, dir, digit} !== {1'b1, 1'b0, 2'b11, 4'd4}) begin
            failures++; $display("FAIL hex_A_illegal: got e=%b v=%b dir=%b d=%0d want 1 0 11 4", seg_err, digit_valid, dir, digit);
        end
`endif
    endtask

    task automatic test_random;
        logic [6:0] s, last;
        logic       stb, c;
        int         r;
        last = pat[0];
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: s = last;
                3: s = pat[(m_digit + 1) % NDIG];
                4: s = pat[(m_digit + NDIG - 1) % NDIG];
                5: s = pat[$urandom_range(0, NDIG - 1)];
                6: s = 7'($urandom);
                7: s = 7'h7F;
                8: s = pat[0];
                default: s = pat[NDIG - 1];
            endcase
            stb = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 199) == 0);
            last = s;
            step(s, stb, c);
            checks++;
            if ({digit, digit_valid, seg_err, dir, acc, wrap_up, wrap_dn, tens} !==
                {4'(m_digit), m_valid, m_err, m_dir, m_acc, m_wu, m_wd, 8'(m_tens)}) begin
                failures++;
                $display("FAIL random_cyc%0d: got d=%0d v=%b e=%b dir=%b acc=%b wu=%b wd=%b tens=%0d expected d=%0d v=%b e=%b dir=%b acc=%b wu=%b wd=%b tens=%0d",
                         i, digit, digit_valid, seg_err, dir, acc, wrap_up, wrap_dn, tens,
                         m_digit, m_valid, m_err, m_dir, m_acc, m_wu, m_wd, m_tens);
            end
        end
    endtask

    initial begin
        model_update(7'h7F, 1'b0, 1'b1);
        test_reset();
        test_debounce();
        test_up_wrap();
        test_down_wrap();
        test_error();
        test_clr_mid();
        test_hex();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
